// File: rtl/mat_stream_mult_pkg.sv
// Shared types and sizing for the serial 4x4 stream matrix multiplier.
package mat_pkg;
   localparam int MAT_N  = 4;
   localparam int MAT_DW = 8;
   localparam int MAT_IW = $clog2(MAT_N);
   localparam int MAT_LW = $clog2(2 * MAT_N * MAT_N);
   localparam int MAT_OW = $clog2(MAT_N * MAT_N);

   typedef enum logic [1:0] {
      LOAD,
      COMPUTE,
      OUT
   } mat_state_t;
endpackage

// File: rtl/mat_stream_mult_if.sv
// Valid/ready element streams in (A then B) and out (Res) of the multiplier.
interface mat_stream_if import mat_pkg::*; #(
   parameter int DW = MAT_DW
);
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/mat_stream_mult_mac.sv
// Single DW-bit multiply-accumulate; sum wraps modulo 2^DW, accumulator registered.
module mat_mac import mat_pkg::*; #(
   parameter int DW = MAT_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic          clear,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] sum
);
   logic [DW-1:0] acc;
   logic [DW-1:0] prod;

   // sum is exposed so the final term of a dot product can be stored the same cycle
   always_comb begin
      prod = a * b;
      sum  = clear ? prod : acc + prod;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         acc <= '0;
      else if (en)
         acc <= sum;
   end
endmodule

// File: rtl/mat_stream_mult.sv
// Serial 4x4 matrix multiplier: stream A,B in, one MAC per cycle, stream Res out.
// Optional MATMUL_PACKED_OUT_EN adds res_packed/res_packed_valid.
module mat_stream_mult import mat_pkg::*; #(
   parameter int N  = MAT_N,
   parameter int DW = MAT_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   mat_stream_if.slave   s,
   output logic          busy
`ifdef MATMUL_PACKED_OUT_EN
   ,
   output logic [N*N*DW-1:0] res_packed,
   output logic              res_packed_valid
`endif
);
   localparam int IW = $clog2(N);
   localparam int LW = $clog2(2 * N * N);
   localparam int OW = $clog2(N * N);

   mat_state_t    state;
   logic [IW-1:0] i_idx, j_idx, k_idx;
   logic [LW-1:0] ld_idx;
   logic [OW-1:0] o_idx, o_next;
   logic [DW-1:0] a_mem   [N][N];
   logic [DW-1:0] b_mem   [N][N];
   logic [DW-1:0] res_mem [N][N];
   logic [DW-1:0] mac_sum;

   // Index decode assumes N is a power of two: top load bit picks B, then row, col.
   logic [IW-1:0] ld_row, ld_col, o_row, o_col, n_row, n_col;
   assign ld_row = ld_idx[2*IW-1:IW];
   assign ld_col = ld_idx[IW-1:0];
   assign o_next = o_idx + OW'(1);
   assign n_row  = o_next[OW-1:IW];
   assign n_col  = o_next[IW-1:0];

   mat_mac #(.DW(DW)) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state == COMPUTE),
      .clear (k_idx == '0),
      .a     (a_mem[i_idx][k_idx]),
      .b     (b_mem[k_idx][j_idx]),
      .sum   (mac_sum)
   );

`ifdef MATMUL_PACKED_OUT_EN
   logic [N*N*DW-1:0] packed_next;

   // Res[N-1][N-1] is still in flight on the COMPUTE->OUT edge, so take it from the MAC
   always_comb begin
      packed_next = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            packed_next[(N*N-1-(r*N+c))*DW +: DW] =
               (r == N-1 && c == N-1) ? mac_sum : res_mem[r][c];
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= LOAD;
         ld_idx      <= '0;
         i_idx       <= '0;
         j_idx       <= '0;
         k_idx       <= '0;
         o_idx       <= '0;
         s.in_ready  <= 1'b1;
         s.out_valid <= 1'b0;
         s.out_data  <= '0;
         s.out_last  <= 1'b0;
         busy        <= 1'b0;
`ifdef MATMUL_PACKED_OUT_EN
         res_packed       <= '0;
         res_packed_valid <= 1'b0;
`endif
      end else begin
`ifdef MATMUL_PACKED_OUT_EN
         res_packed_valid <= 1'b0;
`endif
         case (state)
            LOAD: begin
               if (s.in_valid && s.in_ready) begin
                  if (ld_idx[LW-1])
                     b_mem[ld_row][ld_col] <= s.in_data;
                  else
                     a_mem[ld_row][ld_col] <= s.in_data;
                  if (ld_idx == LW'(2*N*N-1)) begin
                     ld_idx     <= '0;
                     state      <= COMPUTE;
                     s.in_ready <= 1'b0;
                     busy       <= 1'b1;
                  end else begin
                     ld_idx <= ld_idx + LW'(1);
                  end
               end
            end
            COMPUTE: begin
               if (k_idx == IW'(N-1)) begin
                  res_mem[i_idx][j_idx] <= mac_sum;
                  k_idx <= '0;
                  if (j_idx == IW'(N-1)) begin
                     j_idx <= '0;
                     if (i_idx == IW'(N-1)) begin
                        i_idx       <= '0;
                        o_idx       <= '0;
                        state       <= OUT;
                        s.out_valid <= 1'b1;
                        s.out_data  <= res_mem[0][0];
                        s.out_last  <= 1'b0;
`ifdef MATMUL_PACKED_OUT_EN
                        res_packed       <= packed_next;
                        res_packed_valid <= 1'b1;
`endif
                     end else begin
                        i_idx <= i_idx + IW'(1);
                     end
                  end else begin
                     j_idx <= j_idx + IW'(1);
                  end
               end else begin
                  k_idx <= k_idx + IW'(1);
               end
            end
            OUT: begin
               if (s.out_ready) begin
                  if (s.out_last) begin
                     o_idx       <= '0;
                     state       <= LOAD;
                     s.out_valid <= 1'b0;
                     s.out_last  <= 1'b0;
                     s.in_ready  <= 1'b1;
                     busy        <= 1'b0;
                  end else begin
                     o_idx      <= o_next;
                     s.out_data <= res_mem[n_row][n_col];
                     s.out_last <= (o_next == OW'(N*N-1));
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   assign o_row = o_idx[OW-1:IW];
   assign o_col = o_idx[IW-1:0];
   logic unused_o;
   assign unused_o = ^{o_row, o_col};
endmodule

// File: tb/tb_mat_stream_mult.sv
// Directed, table-driven checks of mat_stream_mult, plus reset corner sequences.
module tb_mat_stream_mult;
   import mat_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   int   checks = 0;
   int   errors = 0;

   mat_stream_if #(.DW(8)) s ();

`ifdef MATMUL_PACKED_OUT_EN
   logic [127:0] res_packed;
   logic         res_packed_valid;
   int           pulse_cnt = 0;
`endif

   mat_stream_mult dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (s),
      .busy  (busy)
`ifdef MATMUL_PACKED_OUT_EN
      ,
      .res_packed       (res_packed),
      .res_packed_valid (res_packed_valid)
`endif
   );

   always #5 clk = ~clk;

`ifdef MATMUL_PACKED_OUT_EN
   always @(negedge clk) if (res_packed_valid === 1'b1) pulse_cnt++;
`endif

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic [127:0] a;
      logic [127:0] b;
      logic [127:0] exp;
      bit           gaps;
      bit           bp;
   } vec_t;

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [7:0] getElem(input logic [127:0] m, input int idx);
      return m[(15-idx)*8 +: 8];
   endfunction

   task automatic resetPulse();
      @(negedge clk);
      rst_n      = 1'b0;
      s.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_in_ready"},  s.in_ready,  1'b1);
      checkOutput({tag, "_out_valid"}, s.out_valid, 1'b0);
      checkOutput({tag, "_out_data"},  s.out_data,  8'h00);
      checkOutput({tag, "_out_last"},  s.out_last,  1'b0);
      checkOutput({tag, "_busy"},      busy,        1'b0);
   endtask

   task automatic applyStimulus(input logic [127:0] a, input logic [127:0] b,
                                input logic [127:0] exp, input bit gaps, input bit bp,
                                input int out_limit);
      int   load_bad = 0;
      int   rdy_bad = 0;
      int   busy_bad = 0;
      int   lat = 0;
      int   n = 0;
      int   cyc = 0;
      bit   prev_stall = 1'b0;
      logic [7:0] held_d = '0;
      logic held_l = 1'b0;
`ifdef MATMUL_PACKED_OUT_EN
      int   pulses_before = pulse_cnt;
`endif
      for (int idx = 0; idx < 32; idx++) begin
         if (gaps) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
               @(negedge clk);
               s.in_valid = 1'b0;
            end
         end
         @(negedge clk);
         if (s.in_ready !== 1'b1) load_bad++;
         s.in_valid = 1'b1;
         s.in_data  = (idx < 16) ? getElem(a, idx) : getElem(b, idx - 16);
      end
      @(posedge clk);
      #1;
      s.in_valid = 1'b0;
      while (s.out_valid !== 1'b1 && lat < 200) begin
         if (s.in_ready !== 1'b0) rdy_bad++;
         if (busy !== 1'b1) busy_bad++;
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("load_in_ready", load_bad, 0);
      checkOutput("latency", lat, 64);
`ifdef MATMUL_PACKED_OUT_EN
      checkOutput("packed_valid", res_packed_valid, 1'b1);
      checkOutput("packed_value", res_packed, exp);
`endif
      while (n < out_limit && cyc < 400) begin
         s.out_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
         if (prev_stall) begin
            checkOutput("hold_data", s.out_data, held_d);
            checkOutput("hold_last", s.out_last, held_l);
         end
         if (s.in_ready !== 1'b0) rdy_bad++;
         if (busy !== 1'b1) busy_bad++;
         if (s.out_valid === 1'b1 && s.out_ready) begin
            checkOutput($sformatf("data%0d", n), s.out_data, getElem(exp, n));
            checkOutput($sformatf("last%0d", n), s.out_last, n == 15);
            n++;
         end
         prev_stall = (s.out_valid === 1'b1) && !s.out_ready;
         held_d     = s.out_data;
         held_l     = s.out_last;
         @(posedge clk);
         #1;
         cyc++;
      end
      s.out_ready = 1'b1;
      checkOutput("delivered", n, out_limit);
      checkOutput("busy_in_ready", rdy_bad, 0);
      checkOutput("busy_flag", busy_bad, 0);
      if (out_limit == 16) begin
         checkOutput("after_last_in_ready",  s.in_ready,  1'b1);
         checkOutput("after_last_out_valid", s.out_valid, 1'b0);
         checkOutput("after_last_busy",      busy,        1'b0);
`ifdef MATMUL_PACKED_OUT_EN
         checkOutput("packed_pulses", pulse_cnt - pulses_before, 1);
`endif
      end
   endtask

   localparam logic [127:0] IDENT = 128'h01000000_00010000_00000100_00000001;
   localparam logic [127:0] SEQ   = 128'h01020304_05060708_090A0B0C_0D0E0F10;
   localparam logic [127:0] DIAG2 = 128'h02000000_00020000_00000200_00000002;
   localparam logic [127:0] EVEN  = 128'h02040608_0A0C0E10_12141618_1A1C1E20;

   initial begin
      vec_t vecs [6];
      vecs[0] = '{IDENT,          SEQ,            SEQ,                   1'b0, 1'b0};
      vecs[1] = '{{16{8'h40}},    {16{8'h01}},    {16{8'h00}},           1'b0, 1'b0};
      vecs[2] = '{{16{8'h10}},    {16{8'h01}},    {16{8'h40}},           1'b0, 1'b0};
      vecs[3] = '{DIAG2,          SEQ,            EVEN,                  1'b0, 1'b1};
      vecs[4] = '{{16{8'h01}},    SEQ,            {4{32'h1C202428}},     1'b1, 1'b0};
      vecs[5] = '{{16{8'h02}},    {16{8'h02}},    {16{8'h10}},           1'b0, 1'b0};

      s.in_valid  = 1'b0;
      s.in_data   = '0;
      s.out_ready = 1'b1;
      rst_n       = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checkResetState("reset");

      for (int t = 0; t < 6; t++) begin
         $display("[TB] vector %0d", t);
         applyStimulus(vecs[t].a, vecs[t].b, vecs[t].exp, vecs[t].gaps, vecs[t].bp, 16);
      end

      $display("[TB] reset after 20 input beats");
      for (int idx = 0; idx < 20; idx++) begin
         @(negedge clk);
         s.in_valid = 1'b1;
         s.in_data  = 8'hA5;
      end
      resetPulse();
      checkResetState("rst_load");
      applyStimulus(IDENT, SEQ, SEQ, 1'b0, 1'b0, 16);

      $display("[TB] reset after 5 output beats");
      applyStimulus(IDENT, SEQ, SEQ, 1'b0, 1'b0, 5);
      resetPulse();
      checkResetState("rst_out");
      applyStimulus(DIAG2, SEQ, EVEN, 1'b0, 1'b0, 16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mat_stream_mult.md
# mat_stream_mult

Sequential 4x4 matrix multiplier with byte-stream interfaces on both ends. Operands A and B arrive one element per beat over a valid/ready input stream. The block computes Res = A*B with a single MAC, one product per cycle, and returns Res one element per beat over a valid/ready output stream. It is the serial, low-area counterpart to the combinational packed multiplier, and it sits between the transform-setup logic and the graphics datapath.

## Interface
- `N`, 4: matrix dimension; counters are sized `$clog2(N)`.
- `DW`, 8: element width for A, B and Res.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  input element valid.
- `in_data`  in  DW  input element; A in row-major order first, then B in row-major order.
- `in_ready`  out  1  block accepts the input element.
- `out_valid`  out  1  result element valid.
- `out_data`  out  DW  result element, Res in row-major order.
- `out_last`  out  1  high with element Res[N-1][N-1].
- `out_ready`  in  1  consumer accepts the result element.
- `busy`  out  1  high in COMPUTE and OUT.

## Operation
- States and transitions:
  - LOAD to COMPUTE, after the last input beat is accepted.
  - COMPUTE to OUT, after the MAC for (N-1,N-1,N-1).
  - OUT to LOAD, after the beat with `out_last` is accepted.
- LOAD:
  - `in_ready`=1.
  - Each handshake (`in_valid & in_ready`) writes the element to A or B storage at the current load index, 0..2N²-1.
  - Indices 0..N²-1 go to A[i][j], row-major.
  - Indices N²..2N²-1 go to B[i][j], row-major.
- COMPUTE:
  - `in_ready`=0.
  - Loop order is i outer, j middle, k inner; one step per cycle, N³ cycles in total.
  - At k=0 the accumulator loads A[i][0]*B[0][j]. Otherwise acc = acc + A[i][k]*B[k][j].
  - At k=N-1, Res[i][j] is written with the final sum.
- Arithmetic:
  - Products and sums are truncated modulo 2^DW; no saturation and no overflow flag.
  - Operands and result are unsigned.
- OUT:
  - `out_valid`=1 and `out_data`=Res[oi][oj].
  - The index advances only on `out_valid & out_ready`.
  - `out_data` and `out_last` hold stable while `out_ready`=0.
- Storage for A, B and Res is not cleared between jobs. Every entry is overwritten before it is read.

## Timing
- Reset values:
  - state=LOAD and all indices 0.
  - `in_ready`=1.
  - `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0.
- Reset mid-operation discards any partial load, compute or output. The next accepted beat is A[0][0].
- Latency:
  - The edge that accepts input beat 2N²-1 moves the state to COMPUTE.
  - `out_valid` is first high N³ cycles later, i.e. 64 cycles at N=4.
- Throughput: one job per 2N² + N³ + N² cycles minimum, i.e. 112 cycles at N=4 with no stalls.
- Stalls:
  - `in_valid`=0 during LOAD stalls loading with no side effect.
  - `out_ready`=0 during OUT stalls output indefinitely.
- `in_ready` is a registered function of state only. It does not depend on `in_valid` and has no combinational input-to-output path.
- Back-to-back jobs: the cycle after the `out_last` handshake, `in_ready`=1.

## Configuration
- `MATMUL_PACKED_OUT_EN`.
- Defined:
  - Adds output `res_packed` [N*N*DW-1:0] and output `res_packed_valid`.
  - `res_packed` holds Res row-major, with Res[0][0] in the MSBs.
  - `res_packed_valid` is a one-cycle pulse on the cycle COMPUTE enters OUT.
  - Both outputs reset to 0.
- Undefined: neither port exists. The streamed output is unaffected in both builds.

## Structure
- Package `mat_pkg` holds:
  - the state enum `mat_state_t` (LOAD, COMPUTE, OUT);
  - constants `MAT_N`=4 and `MAT_DW`=8;
  - the index width derived from them.
- Sub-module `mat_mac`:
  - one DW-bit multiply-accumulate with a `clear` input that selects load versus accumulate;
  - the result is registered;
  - the sum wraps modulo 2^DW.
- The top level holds the FSM, the i/j/k counters, the load index and the output index, and the A/B/Res register arrays.

## Test plan
- Identity: A=I, B elements 1..16 row-major.
  - Output is 1..16 in order, `out_last` on 16, first `out_valid` 64 cycles after the last input.
- Wrap: A all 0x40, B all 0x01.
  - All 16 outputs are 0x00, since 4*64=256 wraps.
  - Second job with A all 0x10 and B all 0x01: all outputs are 0x40.
- Backpressure: `out_ready` toggles 1,0,0,1 repeating.
  - Every element is delivered exactly once, in order.
  - `out_data` is stable while stalled.
- Input gaps: `in_valid` is randomly low during load.
  - The result equals the result with no gaps.
  - `in_ready`=0 throughout COMPUTE and OUT.
- Reset mid-operation: assert `rst_n`=0 for one cycle after 20 input beats, and separately after 5 output beats.
  - All outputs return to reset values.
  - A fresh 32-beat job then produces the correct result.
- With `MATMUL_PACKED_OUT_EN` defined and A=B=all 2:
  - `res_packed` = 128'h10101010...10.
  - `res_packed_valid` pulses once per job.
